// File: rtl/data_mem_arbiter.sv
// Signed 8-bit data memory shared by processor (P) and host (H) ports through a
// req/gnt/rvalid handshake. Define DMEM_ARB_RR_EN for round-robin arbitration (default: H priority).
module data_mem_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [7:0]    p_wdata,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [7:0]    p_rdata,

    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [7:0]    h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [7:0]    h_rdata,

    output logic          err,
    output logic          busy
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q;
    logic          sel_h_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;

    logic          p_gnt_q, h_gnt_q;
    logic          p_rvalid_q, h_rvalid_q;
    logic [7:0]    p_rdata_q, h_rdata_q;
    logic          err_q;

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // the declaration initialiser gives the all-zero power-up contents.
    logic [7:0]    mem_q [DEPTH] = '{default: 8'h00};

`ifdef DMEM_ARB_RR_EN
    logic          last_h_q;
`endif

    logic          pick_h_d;
    logic          in_range_d;
    logic [IW-1:0] idx_d;
    logic          mem_we_d;
    logic [7:0]    resp_data_d;

    // Arbitration: on contention the build option decides; otherwise the lone requester wins.
    always_comb begin
        pick_h_d = h_req;
`ifdef DMEM_ARB_RR_EN
        if (p_req && h_req) begin
            pick_h_d = !last_h_q;
        end
`endif
    end

    always_comb begin
        in_range_d  = ({1'b0, addr_q} < DEPTH_W);
        idx_d       = addr_q[IW-1:0];
        mem_we_d    = (state_q == ACCESS) && we_q && in_range_d;
        resp_data_d = 8'h00;
        if (we_q) begin
            resp_data_d = wdata_q;
        end else if (in_range_d) begin
            resp_data_d = mem_q[idx_d];
        end
    end

    // An async reset pulled during ACCESS drops state_q to IDLE, which kills mem_we_d before the edge.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[idx_d] <= wdata_q;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_h_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            p_gnt_q    <= 1'b0;
            h_gnt_q    <= 1'b0;
            p_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            p_rdata_q  <= 8'h00;
            h_rdata_q  <= 8'h00;
            err_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_h_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (p_req || h_req) begin
                        sel_h_q <= pick_h_d;
                        we_q    <= pick_h_d ? h_we    : p_we;
                        addr_q  <= pick_h_d ? h_addr  : p_addr;
                        wdata_q <= pick_h_d ? h_wdata : p_wdata;
                        h_gnt_q <= pick_h_d;
                        p_gnt_q <= !pick_h_d;
                        state_q <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_h_q <= pick_h_d;
`endif
                    end
                end
                ACCESS: begin
                    p_gnt_q    <= 1'b0;
                    h_gnt_q    <= 1'b0;
                    h_rvalid_q <= sel_h_q;
                    p_rvalid_q <= !sel_h_q;
                    h_rdata_q  <= sel_h_q ? resp_data_d : 8'h00;
                    p_rdata_q  <= sel_h_q ? 8'h00 : resp_data_d;
                    err_q      <= !in_range_d;
                    state_q    <= RESP;
                end
                RESP: begin
                    p_rvalid_q <= 1'b0;
                    h_rvalid_q <= 1'b0;
                    p_rdata_q  <= 8'h00;
                    h_rdata_q  <= 8'h00;
                    err_q      <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p_gnt    = p_gnt_q;
    assign h_gnt    = h_gnt_q;
    assign p_rvalid = p_rvalid_q;
    assign h_rvalid = h_rvalid_q;
    assign p_rdata  = p_rdata_q;
    assign h_rdata  = h_rdata_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter (DEPTH=8, AW=4 so out-of-range
// addresses are expressible). Expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_req, p_we, h_req, h_we;
    logic [3:0] p_addr, h_addr;
    logic [7:0] p_wdata, h_wdata;
    logic       p_gnt, p_rvalid, h_gnt, h_rvalid, err, busy;
    logic [7:0] p_rdata, h_rdata;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_arbiter #(.DEPTH(8), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .p_req    (p_req),
        .p_we     (p_we),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_rdata  (p_rdata),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single uncontended access with cycle-exact checks: gnt at N+1, rvalid at N+2, IDLE at N+3.
    task automatic access(input bit is_h, input bit we, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata,
                          input bit exp_err, input string tag);
        if (is_h) begin
            h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata;
        end else begin
            p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata;
        end
        step();
        check({tag, " gnt"},       is_h ? h_gnt : p_gnt, 8'd1);
        check({tag, " other gnt"}, is_h ? p_gnt : h_gnt, 8'd0);
        check({tag, " busy acc"},  busy, 8'd1);
        check({tag, " early rv"},  is_h ? h_rvalid : p_rvalid, 8'd0);
        step();
        check({tag, " rvalid"},      is_h ? h_rvalid : p_rvalid, 8'd1);
        check({tag, " other rv"},    is_h ? p_rvalid : h_rvalid, 8'd0);
        check({tag, " rdata"},       is_h ? h_rdata : p_rdata, exp_rdata);
        check({tag, " other rdata"}, is_h ? p_rdata : h_rdata, 8'd0);
        check({tag, " err"},         err, 8'(exp_err));
        check({tag, " gnt drop"},    is_h ? h_gnt : p_gnt, 8'd0);
        if (is_h) h_req = 1'b0; else p_req = 1'b0;
        step();
        check({tag, " busy idle"}, busy, 8'd0);
        check({tag, " rv drop"},   is_h ? h_rvalid : p_rvalid, 8'd0);
        check({tag, " err drop"},  err, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst p_gnt", p_gnt, 8'd0);
        check("rst h_gnt", h_gnt, 8'd0);
        check("rst p_rvalid", p_rvalid, 8'd0);
        check("rst h_rvalid", h_rvalid, 8'd0);
        check("rst p_rdata", p_rdata, 8'd0);
        check("rst h_rdata", h_rdata, 8'd0);
        check("rst err", err, 8'd0);
        check("rst busy", busy, 8'd0);
        #2 rst = 1'b0;
        step();
        check("post-rst idle busy", busy, 8'd0);

        // Host preload of operands a, b, c.
        access(1'b1, 1'b1, 4'd0, 8'hEC, 8'hEC, 1'b0, "hw a");
        access(1'b1, 1'b1, 4'd1, 8'h0A, 8'h0A, 1'b0, "hw b");
        access(1'b1, 1'b1, 4'd2, 8'h02, 8'h02, 1'b0, "hw c");
        access(1'b0, 1'b0, 4'd1, 8'h00, 8'h0A, 1'b0, "pr 1");

        // Contention: P reads 0, H reads 2; H wins in both builds after reset.
        p_req = 1'b1; p_we = 1'b0; p_addr = 4'd0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 4'd2;
        step();
        check("c1 h_gnt", h_gnt, 8'd1);
        check("c1 p_gnt", p_gnt, 8'd0);
        step();
        check("c1 h_rvalid", h_rvalid, 8'd1);
        check("c1 h_rdata", h_rdata, 8'h02);
        check("c1 p_rvalid", p_rvalid, 8'd0);
        check("c1 p_rdata", p_rdata, 8'd0);
        h_req = 1'b0;
        step();
        check("c1 gap busy", busy, 8'd0);
        check("c1 gap p_gnt", p_gnt, 8'd0);
        step();
        check("c1 p_gnt", p_gnt, 8'd1);
        check("c1 h_gnt late", h_gnt, 8'd0);
        step();
        check("c1 p_rvalid", p_rvalid, 8'd1);
        check("c1 p_rdata", p_rdata, 8'hEC);
        p_req = 1'b0;
        step();
        check("c1 end busy", busy, 8'd0);

        // Second contention with H re-requesting after its grant.
        p_req = 1'b1; p_we = 1'b0; p_addr = 4'd0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 4'd1;
        step();
        check("c2 first h_gnt", h_gnt, 8'd1);
        check("c2 first p_gnt", p_gnt, 8'd0);
        step();
        check("c2 first h_rdata", h_rdata, 8'h0A);
        h_addr = 4'd2;
        step();
        step();
`ifdef DMEM_ARB_RR_EN
        check("c2 rr p_gnt", p_gnt, 8'd1);
        check("c2 rr h_gnt", h_gnt, 8'd0);
        step();
        check("c2 rr p_rdata", p_rdata, 8'hEC);
        p_req = 1'b0;
        step();
        step();
        check("c2 rr h_gnt", h_gnt, 8'd1);
        step();
        check("c2 rr h_rdata", h_rdata, 8'h02);
        h_req = 1'b0;
        step();
`else
        check("c2 fp h_gnt", h_gnt, 8'd1);
        check("c2 fp p_gnt", p_gnt, 8'd0);
        step();
        check("c2 fp h_rdata", h_rdata, 8'h02);
        h_req = 1'b0;
        step();
        step();
        check("c2 fp p_gnt", p_gnt, 8'd1);
        step();
        check("c2 fp p_rdata", p_rdata, 8'hEC);
        p_req = 1'b0;
        step();
`endif
        check("c2 end busy", busy, 8'd0);

        // Out-of-range accesses: read returns 0 with err, write is dropped.
        access(1'b0, 1'b0, 4'd9, 8'h00, 8'h00, 1'b1, "pr oor");
        access(1'b0, 1'b1, 4'd9, 8'h4D, 8'h4D, 1'b1, "pw oor");
        access(1'b1, 1'b0, 4'd1, 8'h00, 8'h0A, 1'b0, "hr 1 intact");

        // Reset pulse during ACCESS of a P write: no rvalid, write never lands.
        p_req = 1'b1; p_we = 1'b1; p_addr = 4'd3; p_wdata = 8'd55;
        step();
        check("rstmid p_gnt", p_gnt, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid p_gnt clr", p_gnt, 8'd0);
        check("rstmid busy clr", busy, 8'd0);
        check("rstmid p_rvalid", p_rvalid, 8'd0);
        p_req = 1'b0; p_we = 1'b0;
        #1 rst = 1'b0;
        step();
        check("rstmid no rvalid", p_rvalid, 8'd0);
        check("rstmid err", err, 8'd0);
        access(1'b1, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, "hr 3 after rst");

        // Back-to-back H reads with req held high: grants 3 cycles apart, one idle cycle.
        h_req = 1'b1; h_we = 1'b0; h_addr = 4'd0;
        step();
        check("b2b g1", h_gnt, 8'd1);
        step();
        check("b2b rv1", h_rvalid, 8'd1);
        check("b2b rd1", h_rdata, 8'hEC);
        check("b2b busy resp", busy, 8'd1);
        step();
        check("b2b idle busy", busy, 8'd0);
        check("b2b idle gnt", h_gnt, 8'd0);
        check("b2b idle rdata", h_rdata, 8'd0);
        step();
        check("b2b g2", h_gnt, 8'd1);
        check("b2b busy2", busy, 8'd1);
        step();
        check("b2b rv2", h_rvalid, 8'd1);
        h_req = 1'b0;
        step();
        check("b2b end busy", busy, 8'd0);
        step();
        check("b2b stay idle gnt", h_gnt, 8'd0);
        check("b2b stay idle busy", busy, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
